alu_rr_sequencer: RTL and testbench

- Shares one 16-bit ALU (ops: AND=00, NOT=01, ADD=10, SAT=11) between two requesters.
- Arbitrates round-robin and captures the winner's operands and opcode into registers.
- Holds the ALU inputs stable for a fixed settle time, captures the ALU output, and returns it to the owning requester over a valid/ready response channel.
- Sits between the front-end requesters and the structural ALU datapath. It is the ALU's only driver.

---
 rtl/alu_rr_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_rr_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// Round-robin front end for a shared combinational ALU: arbitrates two requesters,
// holds the winner's operands on the ALU for ALU_LAT cycles, and returns the result.
module alu_rr_sequencer #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the sender holds valid and payload stable until then, and ready may
  // depend combinationally on valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic             owner;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] result_reg;

  logic grant0;
  logic grant1;
  logic accept;
  logic rsp_hs;

  // rr_ptr only breaks ties; a lone requester always wins.
  assign grant0 = req0_valid & (~req1_valid | ~rr_ptr);
  assign grant1 = req1_valid & (~req0_valid | rr_ptr);
  assign accept = (state == IDLE) & (grant0 | grant1);
  assign rsp_hs = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers load only on the accept edge, so the ALU inputs stay frozen
  // through ISSUE, RESP and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      cnt        <= 4'd0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= 2'd0;
      result_reg <= '0;
    end else if (accept) begin
      a_reg  <= grant1 ? req1_a : req0_a;
      b_reg  <= grant1 ? req1_b : req0_b;
      op_reg <= grant1 ? req1_op : req0_op;
      owner  <= grant1;
      rr_ptr <= ~grant1;
      cnt    <= CNT_INIT;
    end else if (state == ISSUE) begin
      if (cnt == 4'd0) begin
        result_reg <= alu_out;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    rsp0_valid = (state == RESP) & ~owner;
    rsp1_valid = (state == RESP) & owner;
    rsp0_data  = rsp0_valid ? result_reg : '0;
    rsp1_data  = rsp1_valid ? result_reg : '0;
    busy       = (state != IDLE);
    state_dbg  = state;
  end

  assign alu_a = a_reg;
  assign alu_b = b_reg;
  assign alu_s = op_reg;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: a behavioural ALU closes the loop, and two
// instances cover ALU_LAT=2 (main scenarios) and ALU_LAT=4 (operand hold time).
module tb_alu_rr_sequencer;

  localparam int W = 16;

  logic clk;
  logic rst_n;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [1:0]   alu_s;
  logic         busy;
  logic [1:0]   state_dbg;

  logic         req0_valid_l4, req0_ready_l4, req1_ready_l4;
  logic [W-1:0] req0_a_l4;
  logic         rsp0_valid_l4, rsp1_valid_l4;
  logic [W-1:0] rsp0_data_l4, rsp1_data_l4;
  logic [W-1:0] alu_a_l4, alu_b_l4, alu_out_l4;
  logic [1:0]   alu_s_l4;
  logic         busy_l4;
  logic [1:0]   state_dbg_l4;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ALU model: AND, NOT b, ADD, signed saturating add.
  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] s);
    logic [W:0] sum;
    logic [W-1:0] r;
    sum = {a[W-1], a} + {b[W-1], b};
    case (s)
      2'b00:   r = a & b;
      2'b01:   r = ~b;
      2'b10:   r = a + b;
      default: r = (sum[W] ^ sum[W-1]) ? (sum[W] ? 16'h8000 : 16'h7FFF) : sum[W-1:0];
    endcase
    return r;
  endfunction

  assign alu_out    = alu_model(alu_a, alu_b, alu_s);
  assign alu_out_l4 = alu_model(alu_a_l4, alu_b_l4, alu_s_l4);

  alu_rr_sequencer #(.WIDTH(W), .ALU_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .busy(busy), .state_dbg(state_dbg)
  );

  alu_rr_sequencer #(.WIDTH(W), .ALU_LAT(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid_l4), .req0_ready(req0_ready_l4), .req0_a(req0_a_l4), .req0_b(16'h2222), .req0_op(2'b10),
    .req1_valid(1'b0), .req1_ready(req1_ready_l4), .req1_a(16'h0000), .req1_b(16'h0000), .req1_op(2'b00),
    .rsp0_valid(rsp0_valid_l4), .rsp0_ready(1'b1), .rsp0_data(rsp0_data_l4),
    .rsp1_valid(rsp1_valid_l4), .rsp1_ready(1'b1), .rsp1_data(rsp1_data_l4),
    .alu_a(alu_a_l4), .alu_b(alu_b_l4), .alu_s(alu_s_l4), .alu_out(alu_out_l4),
    .busy(busy_l4), .state_dbg(state_dbg_l4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
    rsp0_ready = 0; rsp1_ready = 0;
    req0_valid_l4 = 0; req0_a_l4 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic drive_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op);
    if (idx == 0) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic wait_ready(input int idx, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if ((idx == 0 && req0_ready) || (idx == 1 && req1_ready)) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_rsp(input int idx, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if ((idx == 0 && rsp0_valid) || (idx == 1 && rsp1_valid)) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  // Scenarios
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    checks++;
    if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/rdy0/rdy1/v0/v1=%b expected 00000",
               {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    checks++;
    if ({alu_a, alu_b, alu_s, rsp0_data, rsp1_data, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_data: got alu_a=%h alu_b=%h alu_s=%b d0=%h d1=%h st=%0d expected all 0",
               alu_a, alu_b, alu_s, rsp0_data, rsp1_data, state_dbg);
    end
    step();
    rst_n = 1;
    step();
    checks++;
    if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 00000",
               {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
  endtask

  task automatic test_single_op();
    do_reset();
    rsp0_ready = 1;
    drive_req(0, 16'h0003, 16'h0004, 2'b10);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got rdy0=%b rdy1=%b expected 1 0", req0_ready, req1_ready);
    end
    step();  // accept edge k
    req0_valid = 0;
    checks++;
    if ({busy, req0_ready, rsp0_valid, alu_a, alu_b, alu_s} !== {3'b100, 16'h0003, 16'h0004, 2'b10}) begin
      errors++;
      $display("FAIL single_issue: got busy=%b rdy0=%b v0=%b a=%h b=%h s=%b expected 1 0 0 0003 0004 10",
               busy, req0_ready, rsp0_valid, alu_a, alu_b, alu_s);
    end
    step();  // k+1
    checks++;
    if (rsp0_valid !== 1'b0 || rsp0_data !== 16'h0) begin
      errors++;
      $display("FAIL single_early: got v0=%b d0=%h expected 0 0000", rsp0_valid, rsp0_data);
    end
    step();  // k+2
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h0007 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: got v0=%b d0=%h v1=%b expected 1 0007 0", rsp0_valid, rsp0_data, rsp1_valid);
    end
    step();  // handshake taken at k+2 -> IDLE
    checks++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000 || rsp0_data !== 16'h0 || alu_a !== 16'h0003) begin
      errors++;
      $display("FAIL single_done: got v0=%b v1=%b busy=%b d0=%h alu_a=%h expected 0 0 0 0000 0003",
               rsp0_valid, rsp1_valid, busy, rsp0_data, alu_a);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int who;
    do_reset();
    rsp0_ready = 1;
    rsp1_ready = 1;
    drive_req(0, 16'hF0F0, 16'hFF00, 2'b00);
    drive_req(1, 16'h0000, 16'h00FF, 2'b01);
    // Two full rounds with both requesters continuously valid.
    for (int g = 0; g < 4; g++) begin
      #1;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
        if (req0_ready || req1_ready) begin ok = 1; break; end
        step();
      end
      who = req1_ready ? 1 : 0;
      checks++;
      if (!ok || who !== (g % 2) || (req0_ready && req1_ready)) begin
        errors++;
        $display("FAIL contention_grant%0d: got ok=%0d winner=%0d rdy=%b%b expected winner %0d",
                 g, ok, who, req0_ready, req1_ready, g % 2);
      end
      exp_q.push_back(who == 0 ? 16'hF000 : 16'hFF00);
      step();
      wait_rsp(who, 8, ok);
      checks++;
      if (!ok || (who == 0 ? rsp0_data : rsp1_data) !== exp_q[0] ||
          (who == 0 ? rsp1_valid : rsp0_valid) !== 1'b0) begin
        errors++;
        $display("FAIL contention_rsp%0d: got ok=%0d d0=%h d1=%h v0=%b v1=%b expected data %h on %0d",
                 g, ok, rsp0_data, rsp1_data, rsp0_valid, rsp1_valid, exp_q[0], who);
      end
      void'(exp_q.pop_front());
      if (g == 3) req0_valid = 0;
      step();
    end
    // Third round: req1 alone first, req0 joins a cycle later.
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL round3_req1: got rdy0=%b rdy1=%b expected 0 1", req0_ready, req1_ready);
    end
    step();
    req1_valid = 0;
    drive_req(0, 16'h1234, 16'h00FF, 2'b00);
    wait_rsp(1, 8, ok);
    step();
    wait_ready(0, 4, ok);
    checks++;
    if (!ok || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL round3_req0: got ok=%0d rdy1=%b expected ok=1 rdy1=0", ok, req1_ready);
    end
    step();
    req0_valid = 0;
    wait_rsp(0, 8, ok);
    checks++;
    if (!ok || rsp0_data !== 16'h0034) begin
      errors++;
      $display("FAIL round3_rsp: got ok=%0d d0=%h expected 0034", ok, rsp0_data);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    rsp1_ready = 0;
    rsp0_ready = 1;
    drive_req(1, 16'h0001, 16'h0002, 2'b10);
    #1;
    step();  // req1 accepted (sole requester)
    req1_valid = 0;
    drive_req(0, 16'hFFFF, 16'h00FF, 2'b00);
    wait_rsp(1, 8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_rsp: got no rsp1_valid expected valid within 8 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp1_valid, busy, req0_ready, rsp0_valid} !== 4'b1100 || rsp1_data !== 16'h0003) begin
        errors++;
        $display("FAIL bp_hold%0d: got v1=%b busy=%b rdy0=%b v0=%b d1=%h expected 1 1 0 0 0003",
                 i, rsp1_valid, busy, req0_ready, rsp0_valid, rsp1_data);
      end
      step();
    end
    rsp1_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hs_cycle: got rdy0=%b expected 0", req0_ready);
    end
    step();  // handshake edge
    checks++;
    if ({rsp1_valid, busy, req0_ready} !== 3'b001 || rsp1_data !== 16'h0) begin
      errors++;
      $display("FAIL bp_after: got v1=%b busy=%b rdy0=%b d1=%h expected 0 0 1 0000",
               rsp1_valid, busy, req0_ready, rsp1_data);
    end
    step();
    req0_valid = 0;
    wait_rsp(0, 8, ok);
    checks++;
    if (!ok || rsp0_data !== 16'h00FF) begin
      errors++;
      $display("FAIL bp_req0: got ok=%0d d0=%h expected 00FF", ok, rsp0_data);
    end
    step();
  endtask

  task automatic test_alu_stability();
    do_reset();
    req0_valid_l4 = 1;
    req0_a_l4 = 16'h1111;
    #1;
    checks++;
    if (req0_ready_l4 !== 1'b1) begin
      errors++;
      $display("FAIL l4_ready: got %b expected 1", req0_ready_l4);
    end
    step();  // accept edge k
    req0_valid_l4 = 0;
    req0_a_l4 = 16'hAAAA;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (alu_a_l4 !== 16'h1111 || alu_s_l4 !== 2'b10 || rsp0_valid_l4 !== 1'b0 || busy_l4 !== 1'b1) begin
        errors++;
        $display("FAIL l4_issue%0d: got alu_a=%h s=%b v0=%b busy=%b expected 1111 10 0 1",
                 i, alu_a_l4, alu_s_l4, rsp0_valid_l4, busy_l4);
      end
      step();
    end
    checks++;
    if (rsp0_valid_l4 !== 1'b1 || rsp0_data_l4 !== 16'h3333 || rsp1_valid_l4 !== 1'b0) begin
      errors++;
      $display("FAIL l4_rsp: got v0=%b d0=%h v1=%b expected 1 3333 0", rsp0_valid_l4, rsp0_data_l4, rsp1_valid_l4);
    end
    step();
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    do_reset();
    rsp0_ready = 1;
    drive_req(0, 16'h0005, 16'h0006, 2'b10);
    #1;
    step();  // accept
    req0_valid = 0;
    step();  // second ISSUE cycle
    rst_n = 0;
    #1;
    checks++;
    if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0 ||
        {alu_a, alu_b, alu_s} !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL midrst_out: got busy=%b rdy=%b%b v=%b%b a=%h b=%h s=%b st=%0d expected all 0",
               busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_a, alu_b, alu_s, state_dbg);
    end
    step();
    rst_n = 1;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp0_valid || rsp1_valid || busy) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_spurious: got activity after reset expected idle");
    end
    drive_req(0, 16'h0F0F, 16'h00FF, 2'b00);
    #1;
    step();
    req0_valid = 0;
    wait_rsp(0, 8, ok);
    checks++;
    if (!ok || rsp0_data !== 16'h000F) begin
      errors++;
      $display("FAIL midrst_next: got ok=%0d d0=%h expected 000F", ok, rsp0_data);
    end
    step();
  endtask

  task automatic test_sat_passthrough();
    bit ok;
    do_reset();
    rsp1_ready = 1;
    drive_req(1, 16'h7FFF, 16'h0001, 2'b11);
    #1;
    step();
    req1_valid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (alu_s !== 2'b11 || alu_a !== 16'h7FFF || alu_b !== 16'h0001) begin
        errors++;
        $display("FAIL sat_issue%0d: got s=%b a=%h b=%h expected 11 7FFF 0001", i, alu_s, alu_a, alu_b);
      end
      step();
    end
    wait_rsp(1, 4, ok);
    checks++;
    if (!ok || rsp1_data !== 16'h7FFF || rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_rsp: got ok=%0d d1=%h v0=%b expected 7FFF 0", ok, rsp1_data, rsp0_valid);
    end
    step();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_alu_stability();
    test_reset_mid_issue();
    test_sat_passthrough();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
